// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Synchronises one raw asynchronous input and rejects glitches
//            shorter than FILTER_LEN cycles. Produces a clean level d with
//            one-cycle rise/fall strobes and flags a stuck input (no d edge
//            for TIMEOUT cycles).
// Options  : INPUT_CONDITIONER_GLITCH_CNT_EN - when defined, glitch_count
//            counts rejected pulses; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT     = 32'd100000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        raw,
  input  logic        clear_stats,
  output logic        d,
  output logic        rise,
  output logic        fall,
  output logic        stuck,
  output logic [15:0] glitch_count
);

  localparam logic [1:0]  c_low       = 2'd0;
  localparam logic [1:0]  c_pend_high = 2'd1;
  localparam logic [1:0]  c_high      = 2'd2;
  localparam logic [1:0]  c_pend_low  = 2'd3;
  localparam logic [8:0]  c_filter    = 9'(FILTER_LEN);
  localparam logic [31:0] c_timeout   = 32'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [7:0]             r_cnt;
  logic [7:0]             w_cnt_nxt;
  logic [8:0]             w_cnt_inc;
  logic                   r_d;
  logic                   w_d_nxt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_glitch;
  logic [31:0]            r_idle;
  logic [31:0]            w_idle_nxt;
  logic                   r_stuck;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign d    = r_d;
  assign rise = r_rise;
  assign fall = r_fall;
  assign stuck = r_stuck;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  // Filter FSM: a level change is accepted only after FILTER_LEN equal samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_glitch    = 1'b0;
    w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
    case (r_state)
      c_low: begin
        if (w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = c_high;
            w_d_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_state_nxt = c_pend_high;
            w_cnt_nxt   = 8'd1;
          end
        end
      end
      c_pend_high: begin
        if (w_s) begin
          if (w_cnt_inc == c_filter) begin
            w_state_nxt = c_high;
            w_d_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc[7:0];
          end
        end else begin
          w_state_nxt = c_low;
          w_cnt_nxt   = 8'd0;
          w_glitch    = 1'b1;
        end
      end
      c_high: begin
        if (!w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = c_low;
            w_d_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_state_nxt = c_pend_low;
            w_cnt_nxt   = 8'd1;
          end
        end
      end
      c_pend_low: begin
        if (!w_s) begin
          if (w_cnt_inc == c_filter) begin
            w_state_nxt = c_low;
            w_d_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc[7:0];
          end
        end else begin
          w_state_nxt = c_high;
          w_cnt_nxt   = 8'd0;
          w_glitch    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_low;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Register FSM state, filtered level and edge strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_low;
      r_cnt   <= 8'd0;
      r_d     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Idle count restarts on the edge that loads a strobe, so stuck drops with it.
  always_comb begin
    w_idle_nxt = r_idle;
    if (w_rise_nxt || w_fall_nxt)  w_idle_nxt = 32'd0;
    else if (r_idle != c_timeout)  w_idle_nxt = r_idle + 32'd1;
  end

  // Track cycles since the last d edge and raise stuck at the timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle  <= 32'd0;
      r_stuck <= 1'b0;
    end else begin
      r_idle  <= w_idle_nxt;
      r_stuck <= (w_idle_nxt == c_timeout);
    end
  end

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  logic [15:0] r_glitch_cnt;

  assign glitch_count = r_glitch_cnt;

  // Saturating count of rejected pulses; a clear overrides a coincident glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                       r_glitch_cnt <= 16'h0000;
    else if (clear_stats)                             r_glitch_cnt <= 16'h0000;
    else if (w_glitch && (r_glitch_cnt != 16'hFFFF))  r_glitch_cnt <= r_glitch_cnt + 16'd1;
  end
`else
  logic w_unused_stats;

  assign glitch_count   = 16'h0000;
  assign w_unused_stats = clear_stats ^ w_glitch;
`endif

endmodule
`default_nettype wire
